// File: rtl/insn_sequencer_if.sv
// Handshake bundle between the DekatronPC sequencer and its execution units
// (instruction-pointer line, address-pointer line, data line, I/O unit).
interface insn_sequencer_if #(
  parameter int INSN_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  Run;
  logic                  Step;
  logic                  IpRequest;
  logic                  IpReady;
  logic [INSN_WIDTH-1:0] Insn;
  logic                  ApRequest;
  logic                  ApDec;
  logic                  ApReady;
  logic                  DataRequest;
  logic                  DataDec;
  logic                  DataReady;
  logic                  OutRequest;
  logic                  InRequest;
  logic                  IoReady;
  logic                  Busy;
  logic                  Halted;
  logic                  Fault;
  logic [CNT_WIDTH-1:0]  InsnCount;

  modport master (
    input  Run, Step, IpReady, Insn, ApReady, DataReady, IoReady,
    output IpRequest, ApRequest, ApDec, DataRequest, DataDec,
           OutRequest, InRequest, Busy, Halted, Fault, InsnCount
  );

  modport slave (
    output Run, Step, IpReady, Insn, ApReady, DataReady, IoReady,
    input  IpRequest, ApRequest, ApDec, DataRequest, DataDec,
           OutRequest, InRequest, Busy, Halted, Fault, InsnCount
  );
endinterface

// File: rtl/insn_sequencer.sv
// DekatronPC execution controller: fetch, decode, dispatch one operation per
// instruction, with run/step control, halt, handshake watchdog and retire counter.
module insn_sequencer #(
  parameter int INSN_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_WIDTH      = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  insn_sequencer_if.master   bus
);

  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_FETCH      = 7'b0000010,
    S_FETCH_WAIT = 7'b0000100,
    S_EXEC       = 7'b0001000,
    S_EXEC_WAIT  = 7'b0010000,
    S_HALTED     = 7'b0100000,
    S_FAULT      = 7'b1000000
  } state_e;

  localparam int                    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [INSN_WIDTH-1:0] OP_HALT  = INSN_WIDTH'(1);
  localparam logic [INSN_WIDTH-1:0] OP_PLUS  = INSN_WIDTH'(2);
  localparam logic [INSN_WIDTH-1:0] OP_MINUS = INSN_WIDTH'(3);
  localparam logic [INSN_WIDTH-1:0] OP_RIGHT = INSN_WIDTH'(4);
  localparam logic [INSN_WIDTH-1:0] OP_LEFT  = INSN_WIDTH'(5);
  localparam logic [INSN_WIDTH-1:0] OP_OUT   = INSN_WIDTH'(8);
  localparam logic [INSN_WIDTH-1:0] OP_IN    = INSN_WIDTH'(9);

  state_e                state_q, state_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic                  single_q, single_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ip_req_q, ip_req_d;
  logic                  ap_req_q, ap_req_d;
  logic                  ap_dec_q, ap_dec_d;
  logic                  data_req_q, data_req_d;
  logic                  data_dec_q, data_dec_d;
  logic                  out_req_q, out_req_d;
  logic                  in_req_q, in_req_d;
  logic                  retire;
  logic                  unit_rdy;

  // Ready of whichever unit the decoded opcode was dispatched to
  always_comb begin
    unit_rdy = 1'b1;
    case (insn_q)
      OP_PLUS, OP_MINUS: unit_rdy = bus.DataReady;
      OP_RIGHT, OP_LEFT: unit_rdy = bus.ApReady;
      OP_OUT, OP_IN:     unit_rdy = bus.IoReady;
      default:           unit_rdy = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    insn_d     = insn_q;
    single_d   = single_q;
    cnt_d      = cnt_q;
    wd_d       = '0;
    ip_req_d   = 1'b0;
    ap_req_d   = 1'b0;
    ap_dec_d   = ap_dec_q;
    data_req_d = 1'b0;
    data_dec_d = data_dec_q;
    out_req_d  = 1'b0;
    in_req_d   = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Run || bus.Step) begin
          ip_req_d = 1'b1;
          single_d = !bus.Run;
          state_d  = S_FETCH_WAIT;
        end
      end
      // Not entered by the normal flow; issues a fetch if ever reached.
      S_FETCH: begin
        ip_req_d = 1'b1;
        state_d  = S_FETCH_WAIT;
      end
      // wd_q == 0 marks the first wait cycle, where Ready is still stale.
      S_FETCH_WAIT: begin
        if (wd_q != '0 && bus.IpReady) begin
          insn_d  = bus.Insn;
          state_d = S_EXEC;
        end else if (wd_q == WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_EXEC_WAIT;
        case (insn_q)
          OP_PLUS:  begin data_req_d = 1'b1; data_dec_d = 1'b0; end
          OP_MINUS: begin data_req_d = 1'b1; data_dec_d = 1'b1; end
          OP_RIGHT: begin ap_req_d   = 1'b1; ap_dec_d   = 1'b0; end
          OP_LEFT:  begin ap_req_d   = 1'b1; ap_dec_d   = 1'b1; end
          OP_OUT:   out_req_d = 1'b1;
          OP_IN:    in_req_d  = 1'b1;
          OP_HALT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_HALTED;
          end
          default:  retire = 1'b1;
        endcase
      end
      S_EXEC_WAIT: begin
        if (wd_q != '0 && unit_rdy) begin
          retire = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_HALTED, S_FAULT: state_d = state_q;
      default:           state_d = S_IDLE;
    endcase

    // Retire: count, then either stop or chain straight into the next fetch
    if (retire) begin
      cnt_d = cnt_q + 1'b1;
      if (single_q || !bus.Run) begin
        state_d = S_IDLE;
      end else begin
        ip_req_d = 1'b1;
        state_d  = S_FETCH_WAIT;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      insn_q     <= '0;
      single_q   <= 1'b0;
      wd_q       <= '0;
      cnt_q      <= '0;
      ip_req_q   <= 1'b0;
      ap_req_q   <= 1'b0;
      ap_dec_q   <= 1'b0;
      data_req_q <= 1'b0;
      data_dec_q <= 1'b0;
      out_req_q  <= 1'b0;
      in_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      insn_q     <= insn_d;
      single_q   <= single_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      ip_req_q   <= ip_req_d;
      ap_req_q   <= ap_req_d;
      ap_dec_q   <= ap_dec_d;
      data_req_q <= data_req_d;
      data_dec_q <= data_dec_d;
      out_req_q  <= out_req_d;
      in_req_q   <= in_req_d;
    end
  end

  assign bus.IpRequest   = ip_req_q;
  assign bus.ApRequest   = ap_req_q;
  assign bus.ApDec       = ap_dec_q;
  assign bus.DataRequest = data_req_q;
  assign bus.DataDec     = data_dec_q;
  assign bus.OutRequest  = out_req_q;
  assign bus.InRequest   = in_req_q;
  assign bus.Busy        = !(state_q == S_IDLE || state_q == S_HALTED || state_q == S_FAULT);
  assign bus.Halted      = (state_q == S_HALTED);
  assign bus.Fault       = (state_q == S_FAULT);
  assign bus.InsnCount   = cnt_q;

endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
- Top-level execution controller for the DekatronPC core.
- Repeatedly requests the next instruction from the instruction-pointer line, decodes the returned opcode and dispatches one operation to the address-pointer line, the data line or the I/O unit.
- Waits for each unit's Ready before fetching again.
- Provides run/single-step control, halt detection, a stuck-handshake watchdog and a retired-instruction counter.

Parameters:
- INSN_WIDTH, 4, opcode width; must match the instruction-pointer line.
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting for any Ready before fault.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Run  in  1  level; high = free-running execution.
- Step  in  1  one-cycle pulse; execute exactly one instruction while idle.
- IpRequest  out  1  one-cycle fetch-next pulse to the instruction-pointer line.
- IpReady  in  1  instruction-pointer line idle, Insn valid.
- Insn  in  INSN_WIDTH  current opcode.
- ApRequest  out  1  one-cycle address-pointer step pulse.
- ApDec  out  1  direction for ApRequest; 1 = decrement.
- ApReady  in  1  address-pointer line idle.
- DataRequest  out  1  one-cycle data-cell step pulse.
- DataDec  out  1  direction for DataRequest; 1 = decrement.
- DataReady  in  1  data line idle.
- OutRequest  out  1  one-cycle pulse: print current cell.
- InRequest  out  1  one-cycle pulse: read input into current cell.
- IoReady  in  1  I/O unit idle.
- Busy  out  1  high in any state except IDLE, HALTED, FAULT.
- Halted  out  1  HALT opcode executed.
- Fault  out  1  watchdog expired.
- InsnCount  out  CNT_WIDTH  number of retired instructions.

Behaviour:
- Opcodes: 0 NOP, 1 HALT, 2 '+', 3 '-', 4 '>', 5 '<', 6 '[', 7 ']', 8 '.', 9 ','. Codes 10-15 are treated as NOP.
- Reset (asynchronous, any state, mid-handshake included):
  - state = IDLE.
  - All request outputs, ApDec and DataDec = 0.
  - Busy, Halted and Fault = 0.
  - InsnCount = 0.
  - Watchdog counter = 0.
- States: IDLE, FETCH, FETCH_WAIT, EXEC, EXEC_WAIT, HALTED, FAULT. Encoding is one-hot.
- IDLE:
  - If Run or Step, assert IpRequest for one cycle, latch the mode (single if the Step pulse caused the start and Run = 0), go FETCH_WAIT.
  - Step arriving while not in IDLE is ignored.
- FETCH_WAIT:
  - The cycle after a request pulse, Ready is not sampled.
  - From the second cycle onward, IpReady = 1 → register Insn into an internal decode register, go EXEC.
- EXEC (one cycle), drives exactly one one-cycle pulse:
  - '+' / '-' → DataRequest, DataDec = 0 / 1.
  - '>' / '<' → ApRequest, ApDec = 0 / 1.
  - '.' → OutRequest; ',' → InRequest.
  - Then go EXEC_WAIT.
  - NOP, '[' and ']' issue no pulse and retire immediately. Loop matching belongs to the instruction-pointer line on the next fetch.
  - HALT → Halted = 1, go HALTED; HALT is counted as retired.
- EXEC_WAIT: same skip-one-cycle rule, then wait for the Ready of the unit that was targeted. Then retire.
- Retire:
  - InsnCount += 1, wrapping from 2^CNT_WIDTH-1 to 0.
  - If single mode or Run = 0, go IDLE.
  - Otherwise assert IpRequest and go FETCH_WAIT. This gives back-to-back fetch with no idle cycle.
- Run deasserted mid-instruction: the current instruction completes, then IDLE. There is no abort.
- Direction outputs (ApDec, DataDec) are held stable from their pulse until Ready returns.
- Watchdog:
  - Counts cycles in FETCH_WAIT and EXEC_WAIT; cleared on every state change.
  - Reaching TIMEOUT_CYCLES → Fault = 1, go FAULT, all requests 0.
- HALTED and FAULT are sticky; only Rst_n leaves them. Busy = 0 in both.
- Simultaneous Run and Step in IDLE: Run wins (free-running mode).

Test Plan:
- Program "+ + > - HALT", Run = 1, responders return Ready 3 cycles after each pulse → pulse order DataRequest(Dec=0) ×2, ApRequest(Dec=0), DataRequest(Dec=1); then Halted = 1, InsnCount = 5, Busy = 0.
- Run = 0, Step pulse with Insn = '<' → exactly one IpRequest and one ApRequest with ApDec = 1; InsnCount = 1; state returns to IDLE; no further pulses for 50 cycles.
- Insn stream '[' , ']' , NOP, code 12 → four IpRequest pulses, zero datapath pulses, InsnCount = 4.
- DataReady held low after a '+' with TIMEOUT_CYCLES = 16 → Fault = 1 exactly 16 cycles into EXEC_WAIT; later Ready is ignored; Rst_n pulse clears Fault and InsnCount.
- CNT_WIDTH = 4, 17 NOPs in Run mode → InsnCount = 1 after wrap.
- Rst_n asserted during EXEC_WAIT of ',' → InRequest = 0 and state IDLE immediately (asynchronously); Run then restarts cleanly with IpRequest.
